// File: rtl/seg_byte_decoder_pkg.sv
// Shared definitions for the seven-segment byte decoder: segment patterns
// (bit0=a .. bit6=g, active high), the filler pattern and the FSM state type.
package seg_byte_decoder_pkg;

  localparam logic [6:0] SEG_0      = 7'h3F;
  localparam logic [6:0] SEG_1      = 7'h06;
  localparam logic [6:0] SEG_2      = 7'h5B;
  localparam logic [6:0] SEG_3      = 7'h4F;
  localparam logic [6:0] SEG_4      = 7'h66;
  localparam logic [6:0] SEG_5      = 7'h6D;
  localparam logic [6:0] SEG_6      = 7'h7D;
  localparam logic [6:0] SEG_7      = 7'h07;
  localparam logic [6:0] SEG_8      = 7'h7F;
  localparam logic [6:0] SEG_9      = 7'h6F;
  localparam logic [6:0] SEG_A      = 7'h77;
  localparam logic [6:0] SEG_B      = 7'h7C;
  localparam logic [6:0] SEG_C      = 7'h58;
  localparam logic [6:0] SEG_D      = 7'h5E;
  localparam logic [6:0] SEG_E      = 7'h79;
  localparam logic [6:0] SEG_F      = 7'h71;
  localparam logic [6:0] SEG_FILLER = 7'h55;

  // EMPTY: nothing held; HALF: high nibble held; FULL: output byte held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/seg_byte_decoder_decode.sv
// Combinational lookup from a segment pattern to a hex nibble; any pattern
// outside the table (including the filler) yields nibble 0 flagged invalid.
module seg_pattern_decode
  import seg_byte_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_byte_decoder.sv
// Pairs two seven-segment patterns into one byte (first = high nibble) behind
// valid/ready handshakes, with a saturating count of invalid patterns.
module seg_byte_decoder
  import seg_byte_decoder_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       sseg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
);

  // Handshakes: a beat moves when valid and ready are high in the same cycle;
  // the producer holds its data while valid is high and ready is low.

  state_e           state_q, state_d;
  logic [3:0]       hi_nib_q, hi_nib_d;
  logic             hi_err_q, hi_err_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_err_q, out_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0] dec_nib;
  logic       dec_inv;
  logic       xfer;
  logic       take;

  seg_pattern_decode u_decode (
    .pattern (sseg_in),
    .nibble  (dec_nib),
    .invalid (dec_inv)
  );

  assign in_ready  = (state_q != ST_FULL) || out_ready;
  assign xfer      = in_valid && in_ready;
  // sync discards any beat offered alongside it, so it is never consumed.
  assign take      = xfer && !sync;
  assign out_valid = (state_q == ST_FULL);
  assign out_byte  = out_byte_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d    = state_q;
    hi_nib_d   = hi_nib_q;
    hi_err_d   = hi_err_q;
    out_byte_d = out_byte_q;
    out_err_d  = out_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (take) begin
          hi_nib_d = dec_nib;
          hi_err_d = dec_inv;
          state_d  = ST_HALF;
        end
      end
      ST_HALF: begin
        if (sync) begin
          hi_nib_d = 4'h0;
          hi_err_d = 1'b0;
          state_d  = ST_EMPTY;
        end else if (xfer) begin
          out_byte_d = {hi_nib_q, dec_nib};
          out_err_d  = hi_err_q || dec_inv;
          state_d    = ST_FULL;
        end
      end
      ST_FULL: begin
        // The held byte survives sync; it only leaves on out_ready.
        if (out_ready) begin
          if (take) begin
            hi_nib_d = dec_nib;
            hi_err_d = dec_inv;
            state_d  = ST_HALF;
          end else begin
            state_d  = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (take && dec_inv && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      hi_nib_q   <= 4'h0;
      hi_err_q   <= 1'b0;
      out_byte_q <= 8'h00;
      out_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hi_nib_q   <= hi_nib_d;
      hi_err_q   <= hi_err_d;
      out_byte_q <= out_byte_d;
      out_err_q  <= out_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_seg_byte_decoder.sv
// Directed bench for seg_byte_decoder: a default-width instance plus an
// ERR_W=2 instance sharing the same stimulus for the saturation case.
module tb_seg_byte_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] sseg_in = 7'h00;
  logic       out_ready = 1'b0;

  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_err;
  logic [7:0] err_cnt;

  logic       in_ready2;
  logic       out_valid2;
  logic [7:0] out_byte2;
  logic       out_err2;
  logic [1:0] err_cnt2;

  int errors = 0;
  int checks = 0;

  seg_byte_decoder #(.ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sseg_in   (sseg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  seg_byte_decoder #(.ERR_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .sseg_in   (sseg_in),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_byte  (out_byte2),
    .out_err   (out_err2),
    .err_cnt   (err_cnt2)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    sync      = 1'b0;
    in_valid  = 1'b0;
    sseg_in   = 7'h00;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if ({out_valid, out_byte, out_err, err_cnt} !== 18'h0) begin
      errors++; $display("FAIL reset_outputs: got v=%b b=%h e=%b c=%h want all 0",
                         out_valid, out_byte, out_err, err_cnt);
    end
    apply_reset();
  endtask

  task automatic test_basic_pair();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sseg_in   = 7'h66;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pair_half_valid: got %b want 0", out_valid);
    end
    sseg_in = 7'h5E;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte, out_err} !== {1'b1, 8'h4D, 1'b0}) begin
      errors++; $display("FAIL pair_byte: got v=%b b=%h e=%b want v=1 b=4d e=0",
                         out_valid, out_byte, out_err);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL pair_valid_pulse: got %b want 0", out_valid);
    end
  endtask

  task automatic test_invalid_pair();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sseg_in   = 7'h55;
    step();
    sseg_in = 7'h3F;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte, out_err, err_cnt} !== {1'b1, 8'h00, 1'b1, 8'd1}) begin
      errors++; $display("FAIL invalid_pair: got v=%b b=%h e=%b c=%0d want v=1 b=00 e=1 c=1",
                         out_valid, out_byte, out_err, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sseg_in   = 7'h07;
    step();
    sseg_in = 7'h7F;
    step();
    sseg_in = 7'h77;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({out_valid, out_byte, out_err, in_ready} !== {1'b1, 8'h78, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_hold_%0d: got v=%b b=%h e=%b r=%b want v=1 b=78 e=0 r=0",
                           i, out_valid, out_byte, out_err, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_in_ready_release: got %b want 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after_release: got %b want 0", out_valid);
    end
    sseg_in = 7'h7C;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte} !== {1'b1, 8'hAB}) begin
      errors++; $display("FAIL bp_third_as_high: got v=%b b=%h want v=1 b=ab",
                         out_valid, out_byte);
    end
  endtask

  task automatic test_sync_half();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sseg_in   = 7'h06;
    step();
    sync    = 1'b1;
    sseg_in = 7'h5B;
    step();
    sync = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sync_drop_valid: got %b want 0", out_valid);
    end
    sseg_in = 7'h4F;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sync_new_high_valid: got %b want 0", out_valid);
    end
    sseg_in = 7'h07;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte, out_err} !== {1'b1, 8'h37, 1'b0}) begin
      errors++; $display("FAIL sync_byte: got v=%b b=%h e=%b want v=1 b=37 e=0",
                         out_valid, out_byte, out_err);
    end
    // Invalid pattern dropped by sync must not be counted.
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sseg_in   = 7'h3F;
    step();
    sync    = 1'b1;
    sseg_in = 7'h55;
    step();
    sync     = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, err_cnt} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL sync_no_count: got v=%b c=%0d want v=0 c=0",
                         out_valid, err_cnt);
    end
  endtask

  task automatic test_sync_full();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sseg_in   = 7'h6D;
    step();
    sseg_in = 7'h7D;
    step();
    sync    = 1'b1;
    sseg_in = 7'h06;
    step();
    checks++;
    if ({out_valid, out_byte} !== {1'b1, 8'h56}) begin
      errors++; $display("FAIL sync_full_hold: got v=%b b=%h want v=1 b=56",
                         out_valid, out_byte);
    end
    out_ready = 1'b1;
    step();
    sync = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sync_full_release: got %b want 0", out_valid);
    end
    sseg_in = 7'h06;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL sync_full_empty: got %b want 0", out_valid);
    end
    sseg_in = 7'h5B;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte} !== {1'b1, 8'h12}) begin
      errors++; $display("FAIL sync_full_next: got v=%b b=%h want v=1 b=12",
                         out_valid, out_byte);
    end
  endtask

  task automatic test_err_saturate();
    logic [6:0] pats [5];
    pats = '{7'h55, 7'h00, 7'h7E, 7'h01, 7'h55};
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sseg_in = pats[i];
      step();
      if (i == 3) begin
        checks++;
        if (err_cnt2 !== 2'd3) begin
          errors++; $display("FAIL sat_no_wrap: got %0d want 3", err_cnt2);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt2 !== 2'd3) begin
      errors++; $display("FAIL sat_err_w2: got %0d want 3", err_cnt2);
    end
    checks++;
    if (err_cnt !== 8'd5) begin
      errors++; $display("FAIL sat_err_w8: got %0d want 5", err_cnt);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sseg_in   = 7'h06;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_byte, out_err, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL areset_half: got v=%b b=%h e=%b r=%b want v=0 b=00 e=0 r=1",
                         out_valid, out_byte, out_err, in_ready);
    end
    step();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    sseg_in  = 7'h4F;
    step();
    sseg_in = 7'h66;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte, out_err} !== {1'b1, 8'h34, 1'b0}) begin
      errors++; $display("FAIL areset_half_next: got v=%b b=%h e=%b want v=1 b=34 e=0",
                         out_valid, out_byte, out_err);
    end
    // Now reset while FULL with an error byte held.
    out_ready = 1'b0;
    step();
    in_valid = 1'b1;
    sseg_in  = 7'h55;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    sseg_in   = 7'h06;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte, out_err, err_cnt} !== {1'b1, 8'h01, 1'b1, 8'd1}) begin
      errors++; $display("FAIL areset_full_setup: got v=%b b=%h e=%b c=%0d want v=1 b=01 e=1 c=1",
                         out_valid, out_byte, out_err, err_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_byte, out_err, err_cnt} !== 18'h0) begin
      errors++; $display("FAIL areset_full: got v=%b b=%h e=%b c=%0d want all 0",
                         out_valid, out_byte, out_err, err_cnt);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sseg_in   = 7'h79;
    step();
    sseg_in = 7'h71;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_byte, out_err} !== {1'b1, 8'hEF, 1'b0}) begin
      errors++; $display("FAIL areset_full_next: got v=%b b=%h e=%b want v=1 b=ef e=0",
                         out_valid, out_byte, out_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_invalid_pair();
    test_backpressure();
    test_sync_half();
    test_sync_full();
    test_err_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seg_byte_decoder.md
SEG_BYTE_DECODER -- requirements
Module: seg_byte_decoder

Interface
REQ-001 Parameter ERR_W, default 8, width of the invalid-pattern counter.
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 sync  in  1  synchronous flush: discards any held high nibble.
REQ-005 in_valid  in  1  sseg_in carries a pattern this cycle.
REQ-006 in_ready  out  1  block accepts a pattern this cycle.
REQ-007 sseg_in  in  7  active-high segment pattern: bit0=a … bit6=g.
REQ-008 out_valid  out  1  out_byte/out_err are valid.
REQ-009 out_ready  in  1  consumer takes the byte this cycle.
REQ-010 out_byte  out  8  decoded byte: first nibble in [7:4], second in [3:0].
REQ-011 out_err  out  1  at least one nibble of out_byte came from an invalid pattern.
REQ-012 err_cnt  out  ERR_W  saturating count of invalid patterns accepted.

Function
REQ-013 The decode table SHALL be 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9, 0x77→A, 0x7C→B, 0x58→C, 0x5E→D, 0x79→E, 0x71→F.
REQ-014 Every other pattern, including the 0x55 filler, SHALL decode to nibble 0 and be marked invalid.
REQ-015 A transfer SHALL occur when in_valid and in_ready are both high in the same cycle; no other sseg_in value is used.
REQ-016 States: EMPTY (no nibble held), HALF (high nibble held), FULL (output byte held, no nibble held).
REQ-017 In EMPTY, a transfer SHALL store the high nibble and its invalid flag, then go to HALF.
REQ-018 In HALF, a transfer SHALL form the byte and set out_err = high flag OR low flag.
REQ-019 After that HALF transfer, out_valid SHALL rise the next cycle and the state SHALL be FULL; latency from the second transfer to out_valid is 1 cycle.
REQ-020 In FULL, out_valid=1 and out_byte/out_err SHALL be held stable until out_ready=1.
REQ-021 in_ready SHALL be 1 in EMPTY and HALF, and in FULL only when out_ready=1.
REQ-022 In FULL with out_ready=1 and a transfer, the pattern SHALL become the new high nibble and the state SHALL go to HALF.
REQ-023 In FULL with out_ready=1 and no transfer, the state SHALL go to EMPTY and out_valid SHALL fall.
REQ-024 sync=1 in HALF SHALL discard the held nibble and go to EMPTY; a simultaneous transfer SHALL be dropped (sync wins).
REQ-025 A pattern dropped by sync SHALL not be counted in err_cnt.
REQ-026 sync SHALL NOT discard a byte held in FULL; the handshake completes normally.
REQ-027 In FULL, sync with a simultaneous transfer SHALL drop the transfer and go to EMPTY if out_ready=1, otherwise stay FULL.
REQ-028 err_cnt SHALL increment by 1 on each accepted invalid pattern.
REQ-029 err_cnt SHALL saturate at 2^ERR_W−1 and never wrap.
REQ-030 err_cnt SHALL be cleared only by reset.

Reset
REQ-031 rst_n low SHALL immediately force state=EMPTY, out_valid=0, out_byte=0x00, out_err=0, err_cnt=0, and the held nibble and flag to 0.
REQ-032 Reset mid-operation (HALF or FULL) SHALL lose all partial and held data; the first transfer after release is a high nibble.
REQ-033 in_ready SHALL be 1 while in reset.

Structure
REQ-034 The shared package SHALL hold the 16 segment-pattern constants, the filler constant 0x55, and the state enum; the segment encoder uses the same constants.
REQ-035 A combinational sub-module seg_pattern_decode (7-bit pattern → 4-bit nibble + invalid) SHALL hold the table; the FSM, output register and counter live in seg_byte_decoder.

Verification
REQ-036 Send 0x66 then 0x5E with out_ready=1 → out_byte=0x4D, out_err=0, out_valid high for exactly 1 cycle, 1 cycle after the second transfer.
REQ-037 Send 0x55 then 0x3F → out_byte=0x00, out_err=1, err_cnt=1.
REQ-038 Hold out_ready=0 with three patterns offered → byte held stable, in_ready=0 in FULL, third pattern not accepted; release out_ready → third pattern accepted as the high nibble that cycle.
REQ-039 Send 0x06, then sync together with 0x5B, then 0x4F and 0x07 → out_byte=0x37; 0x5B dropped.
REQ-040 With ERR_W=2, send 5 invalid patterns → err_cnt saturates at 3.
REQ-041 Assert rst_n low asynchronously while in HALF and while in FULL → outputs zero immediately; next pair decodes correctly.
